// File: rtl/if_id_inst_queue.sv
// IF->ID instruction queue: a DEPTH-entry FIFO of {exc_type, pc, inst} packets.
// Fetch keeps filling it while decode stalls, and a redirect empties it.
module if_id_inst_queue #(
   parameter int EXC_W = 16,
   parameter int BUS_W = EXC_W + 64,
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               if_id_valid,
   input  logic [BUS_W-1:0]   if_id_bus,
   output logic               q_allowin,
   input  logic               id_allowin,
   output logic               q_id_valid,
   output logic [BUS_W-1:0]   q_id_bus,
   input  logic               flush,
   input  logic               br_flush,
   output logic [PTR_W:0]     q_count,
   output logic               q_empty
);

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [BUS_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W:0]   cnt;
   logic             kill;
   logic             push;
   logic             pop;

   // Handshake flags come only from registered state, so neither side sees a
   // combinational path through the queue.
   assign q_allowin  = (cnt != CNT_FULL);
   assign q_id_valid = (cnt != '0);
   assign q_id_bus   = mem[rptr];
   assign q_count    = cnt;
   assign q_empty    = (cnt == '0);

   assign kill = flush | br_flush;
   assign push = if_id_valid & q_allowin & ~kill;
   assign pop  = q_id_valid & id_allowin & ~kill;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (kill) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         // Power-of-two depth lets the pointers wrap naturally; cnt tells
         // full from empty when they coincide.
         if (push)
            wptr <= wptr + PTR_ONE;
         if (pop)
            rptr <= rptr + PTR_ONE;
         if (push && !pop)
            cnt <= cnt + CNT_ONE;
         else if (pop && !push)
            cnt <= cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= if_id_bus;
   end

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Bench for if_id_inst_queue: directed scenarios plus random traffic, all
// checked against a packet-queue reference model.
module tb_if_id_inst_queue;
   localparam int EXC_W = 16;
   localparam int BUS_W = EXC_W + 64;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clk = 1'b0;
   logic             resetn = 1'b1;
   logic             if_id_valid = 1'b0;
   logic [BUS_W-1:0] if_id_bus = '0;
   logic             id_allowin = 1'b0;
   logic             flush = 1'b0;
   logic             br_flush = 1'b0;
   logic             q_allowin;
   logic             q_id_valid;
   logic [BUS_W-1:0] q_id_bus;
   logic [PTR_W:0]   q_count;
   logic             q_empty;

   int passed = 0;
   int total  = 0;
   logic [BUS_W-1:0] model_q[$];
   logic acc;
   logic done;

   if_id_inst_queue #(.EXC_W(EXC_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .resetn(resetn), .if_id_valid(if_id_valid), .if_id_bus(if_id_bus),
      .q_allowin(q_allowin), .id_allowin(id_allowin), .q_id_valid(q_id_valid),
      .q_id_bus(q_id_bus), .flush(flush), .br_flush(br_flush),
      .q_count(q_count), .q_empty(q_empty)
   );

   always #5 clk = ~clk;

   function automatic logic [BUS_W-1:0] pkt(input logic [15:0] exc, input logic [31:0] pc);
      return {exc, pc, pc ^ 32'hdead_beef};
   endfunction

   task automatic check(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h required %0h", tag, obs, exp);
   endtask

   task automatic check_state(input string tag);
      check({tag, ".count"},   BUS_W'(q_count),    BUS_W'(model_q.size()));
      check({tag, ".allowin"}, BUS_W'(q_allowin),  BUS_W'(model_q.size() != DEPTH));
      check({tag, ".valid"},   BUS_W'(q_id_valid), BUS_W'(model_q.size() != 0));
      check({tag, ".empty"},   BUS_W'(q_empty),    BUS_W'(model_q.size() == 0));
      if (model_q.size() != 0)
         check({tag, ".head"}, q_id_bus, model_q[0]);
   endtask

   // One clock: drive inputs, compare against the model, clock, advance the model.
   task automatic step(input logic v, input logic [BUS_W-1:0] bus, input logic ida,
                       input logic fl, input logic bf, input string tag, output logic pushed);
      logic do_push, do_pop;
      if_id_valid = v;
      if_id_bus   = bus;
      id_allowin  = ida;
      flush       = fl;
      br_flush    = bf;
      check_state(tag);
      do_push = v && (model_q.size() < DEPTH) && !fl && !bf;
      do_pop  = (model_q.size() > 0) && ida && !fl && !bf;
      @(posedge clk);
      #1;
      if (fl || bf)
         model_q.delete();
      else begin
         if (do_pop)
            void'(model_q.pop_front());
         if (do_push)
            model_q.push_back(bus);
      end
      pushed = do_push;
   endtask

   task automatic drain();
      logic p;
      for (int k = 0; k < 3 * DEPTH && model_q.size() != 0; k++)
         step(1'b0, '0, 1'b1, 1'b0, 1'b0, "drain", p);
      check("drain_done", BUS_W'(q_count), BUS_W'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      // Power-on reset
      #1 resetn = 1'b0;
      #1 check_state("reset");
      #10 resetn = 1'b1;

      // Basic flow with ID always ready
      for (int i = 0; i < 3; i++)
         step(1'b1, pkt(16'h0, 32'h1c000000 + 32'(4 * i)), 1'b1, 1'b0, 1'b0, "basic", acc);
      drain();

      // Fill while ID stalls, then release; IF holds the fifth packet
      for (int i = 0; i < 5; i++)
         step(1'b1, pkt(16'h0, 32'h1c000000 + 32'(4 * i)), 1'b0, 1'b0, 1'b0, "full", acc);
      check("full_count", BUS_W'(q_count), BUS_W'(4));
      check("full_allowin", BUS_W'(q_allowin), BUS_W'(0));
      done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         step(1'b1, pkt(16'h0, 32'h1c000010), 1'b1, 1'b0, 1'b0, "release", acc);
         done = acc;
      end
      check("held_accepted", BUS_W'(done), BUS_W'(1));
      drain();

      // Steady push+pop at cnt=2 across pointer wrap
      for (int i = 0; i < 2; i++)
         step(1'b1, pkt(16'h0, 32'h1c000100 + 32'(4 * i)), 1'b0, 1'b0, 1'b0, "wrap_fill", acc);
      for (int i = 2; i < 12; i++)
         step(1'b1, pkt(16'h0, 32'h1c000100 + 32'(4 * i)), 1'b1, 1'b0, 1'b0, "wrap", acc);
      check("wrap_count", BUS_W'(q_count), BUS_W'(2));
      drain();

      // Flush with a concurrent push
      for (int i = 0; i < 3; i++)
         step(1'b1, pkt(16'h0, 32'h1c000200 + 32'(4 * i)), 1'b0, 1'b0, 1'b0, "flush_fill", acc);
      step(1'b1, pkt(16'h0, 32'h1c000020), 1'b1, 1'b1, 1'b0, "flush", acc);
      check("flush_valid", BUS_W'(q_id_valid), BUS_W'(0));
      step(1'b1, pkt(16'h0, 32'h1c008000), 1'b0, 1'b0, 1'b0, "post_flush", acc);
      check("post_flush_pc", BUS_W'(q_id_bus[63:32]), BUS_W'(32'h1c008000));
      drain();

      // Branch flush while ID is ready, then an exception packet passes through
      for (int i = 0; i < 2; i++)
         step(1'b1, pkt(16'h0, 32'h1c000300 + 32'(4 * i)), 1'b0, 1'b0, 1'b0, "br_fill", acc);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, "br_flush", acc);
      check("br_empty", BUS_W'(q_empty), BUS_W'(1));
      step(1'b1, pkt(16'h0400, 32'h1c00a000), 1'b0, 1'b0, 1'b0, "exc_push", acc);
      check("exc_pass", BUS_W'(q_id_bus[BUS_W-1:64]), BUS_W'(16'h0400));
      drain();

      // Asynchronous reset mid-stream at cnt=3
      for (int i = 0; i < 3; i++)
         step(1'b1, pkt(16'h0, 32'h1c000400 + 32'(4 * i)), 1'b0, 1'b0, 1'b0, "rst_fill", acc);
      if_id_valid = 1'b0;
      resetn = 1'b0;
      model_q.delete();
      #1 check_state("async_reset");
      #2 resetn = 1'b1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic v, ida, fl, bf;
         v   = 1'($urandom_range(0, 3) != 0);
         ida = 1'($urandom_range(0, 2) == 0);
         fl  = 1'($urandom_range(0, 15) == 0);
         bf  = 1'($urandom_range(0, 15) == 0);
         step(v, pkt(16'($urandom), 32'($urandom)), ida, fl, bf, "random", acc);
      end
      check_state("final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/if_id_inst_queue.md
Name: if_id_inst_queue

Overview:
- Instruction queue between the IF stage and the ID stage.
- Decouples fetch from decode so that IF can keep fetching while ID is stalled.
- Buffers up to DEPTH fetched packets; each packet carries exception type, pc and instruction, and packets leave in FIFO order.
- Flushes on a WB exception/ertn redirect or an ID branch redirect, so no wrong-path packet reaches ID.

Parameters:
- EXC_W, 16, width of the exception-type vector carried with each packet.
- BUS_W, EXC_W+64, packet width, ordered {exc_type, pc, inst}.
- DEPTH, 4, number of entries; must be a power of two, 2..16.
- PTR_W, log2(DEPTH), width of the read and write pointers.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- if_id_valid  input  1  IF presents a packet this cycle
- if_id_bus  input  BUS_W  packet from IF
- q_allowin  output  1  queue can accept a packet (drives IF's id_allowin)
- id_allowin  input  1  ID accepts the head packet this cycle
- q_id_valid  output  1  head packet valid toward ID
- q_id_bus  output  BUS_W  head packet toward ID
- flush  input  1  WB exception/ertn redirect; drop everything
- br_flush  input  1  ID taken-branch redirect; drop everything queued
- q_count  output  PTR_W+1  number of valid entries
- q_empty  output  1  q_count==0

Behaviour:
- Storage: DEPTH x BUS_W register array, write pointer wptr, read pointer rptr (PTR_W bits each), count cnt (PTR_W+1 bits).
- All state updates on the rising clk edge.
- Reset (resetn low, asynchronous, any time, including mid-transfer):
  - wptr=0, rptr=0, cnt=0.
  - Outputs: q_id_valid=0, q_empty=1, q_count=0, q_allowin=1.
  - Array contents are don't-care and need no reset.
- Push = if_id_valid & q_allowin & ~flush & ~br_flush.
  - Writes if_id_bus to mem[wptr]; wptr increments mod DEPTH.
- Pop = q_id_valid & id_allowin & ~flush & ~br_flush.
  - rptr increments mod DEPTH.
- q_allowin = (cnt != DEPTH).
  - Depends on registered state only; no combinational path from id_allowin.
  - A push arriving while full is ignored; IF must hold the packet.
- q_id_valid = (cnt != 0); q_id_bus = mem[rptr].
  - Output is not bypassed: minimum latency from push to q_id_valid is 1 cycle.
- cnt update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop (both legal when 0<cnt<DEPTH).
  - Simultaneous push and pop at cnt==DEPTH is impossible because q_allowin=0.
  - At cnt==0 no pop occurs.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
  - cnt distinguishes full from empty when wptr==rptr.
- Flush (flush | br_flush):
  - Next cycle rptr=wptr=0 and cnt=0.
  - Push and pop in the same cycle are suppressed; the packet on if_id_bus that cycle is discarded.
  - q_id_valid must be 0 in the cycle after the flush.
  - flush and br_flush together behave identically to either alone.
- Exception fields are opaque payload, passed through unmodified; the queue never drops a packet because of its exc_type.
- The queue adds no combinational path from if_id_valid/if_id_bus to q_id_valid/q_id_bus.

Test Plan:
- Reset: assert resetn=0 mid-stream with cnt=3 -> q_id_valid=0, q_count=0, q_allowin=1 immediately, before the next clk edge.
- Basic flow: push pc 0x1c000000/0x1c000004/0x1c000008 with id_allowin=1 -> ID receives them in order, each 1 cycle after its push; q_count never exceeds 1.
- Full: id_allowin=0, push 5 packets pc 0x1c000000..0x1c000010 -> q_allowin=0 after the 4th push, 5th not stored, q_count=4. Then release id_allowin -> ID receives 0x1c000000..0x1c00000c, and IF's held 0x1c000010 enters when q_allowin returns to 1.
- Wrap and concurrent push/pop: hold cnt=2 while pushing and popping every cycle for 10 cycles -> q_count stays 2, pcs arrive in order across pointer wrap, no loss or duplication.
- Flush with concurrent push: cnt=3 plus push of pc 0x1c000020 in the same cycle as flush=1 -> next cycle q_count=0, q_id_valid=0. The first post-flush push, pc 0x1c008000, is the next packet ID sees.
- br_flush while id_allowin=1 and cnt=2 -> no pop that cycle, queue empty next cycle. Packet exc_type=0x0400 pushed later emerges with exc_type=0x0400 unchanged.
